window_trap_controller: RTL and testbench
=========================================

WINDOW_TRAP_CONTROLLER -- requirements
Module: window_trap_controller

Interface
REQ-001 SHALL have parameter NWINDOWS, default 32, number of register windows (2..32).
REQ-002 SHALL have port Clock  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port PSR_S  in  1  current supervisor bit.
REQ-005 SHALL have port PSR_PS  in  1  current previous-supervisor bit.
REQ-006 SHALL have port PSR_ET  in  1  current trap-enable bit.
REQ-007 SHALL have port PSR_CWP  in  5  current window pointer.
REQ-008 SHALL have port PSR_PIL  in  4  current interrupt level.
REQ-009 SHALL have port WIM  in  32  window invalid mask; bit i marks window i invalid.
REQ-010 SHALL have port Save_Req  in  1  SAVE instruction in execute (1-cycle pulse).
REQ-011 SHALL have port Restore_Req  in  1  RESTORE instruction in execute (pulse).
REQ-012 SHALL have port Rett_Req  in  1  RETT instruction in execute (pulse).
REQ-013 SHALL have port Priv_Op  in  1  executing instruction is privileged.
REQ-014 SHALL have port Interrupt_Level  in  4  external interrupt request level; 0 = none.
REQ-015 SHALL have port Busy  out  1  controller not in IDLE; pipeline stalls.
REQ-016 SHALL have port Trap_Taken  out  1  one-cycle pulse: load TBR.tt and vector PC.
REQ-017 SHALL have port Trap_Type  out  8  tt value, valid while Trap_Taken = 1.
REQ-018 SHALL have port PSR_Fld_Ld  out  1  one-cycle pulse: PSR loads New_S/New_PS/New_ET/New_CWP.
REQ-019 SHALL have ports New_S, New_PS, New_ET (out, 1 each) and New_CWP (out, 5): PSR field values, valid with PSR_Fld_Ld.
REQ-020 SHALL have port Error_Mode  out  1  sticky: trap raised while ET = 0.

Function
REQ-021 SHALL evaluate requests in IDLE only; requests arriving while Busy = 1 SHALL be ignored.
REQ-022 SHALL give priority Rett illegal (tt 0x02) > privileged (tt 0x03) > window_overflow (tt 0x05) > window_underflow (tt 0x06) > interrupt (tt 0x10 + level).
REQ-023 SHALL raise privileged when Priv_Op = 1 and PSR_S = 0.
REQ-024 SHALL raise illegal when Rett_Req = 1 and PSR_ET = 1; Rett with PSR_S = 0 and PSR_ET = 0 SHALL raise privileged.
REQ-025 SHALL compute down = (CWP - 1) mod NWINDOWS and up = (CWP + 1) mod NWINDOWS; 0 - 1 wraps to NWINDOWS-1 and NWINDOWS-1 + 1 wraps to 0.
REQ-026 SHALL raise overflow on Save_Req when WIM[down] = 1, and underflow on Restore_Req or a legal Rett_Req when WIM[up] = 1.
REQ-027 SHALL raise interrupt when PSR_ET = 1 and (Interrupt_Level = 15 or Interrupt_Level > PSR_PIL); Interrupt_Level = 0 SHALL never trap.
REQ-028 Legal SAVE/RESTORE with no trap: next cycle PSR_Fld_Ld = 1, New_CWP = down/up, other New_* = current; Busy = 0 throughout.
REQ-029 Legal RETT with no trap: next cycle PSR_Fld_Ld = 1, New_CWP = up, New_S = PSR_PS, New_ET = 1.
REQ-030 FSM states IDLE -> TRAP_SAVE -> TRAP_VECTOR -> IDLE; trap detection in IDLE enters TRAP_SAVE; Busy = 1 in TRAP_SAVE and TRAP_VECTOR.
REQ-031 TRAP_SAVE SHALL assert PSR_Fld_Ld with New_ET = 0, New_PS = PSR_S, New_S = 1, New_CWP = down; the WIM check is not applied to this CWP decrement.
REQ-032 TRAP_VECTOR SHALL assert Trap_Taken for exactly one cycle with Trap_Type latched at detection.
REQ-033 A trap detected while PSR_ET = 0 SHALL set Error_Mode, enter ERROR, and hold there with Busy = 1 until Reset.
REQ-034 Simultaneous Save_Req and Restore_Req SHALL be treated as Save_Req.

Reset
REQ-035 Reset SHALL force IDLE with Busy, Trap_Taken, PSR_Fld_Ld and Error_Mode = 0, Trap_Type = 0x00 and all New_* = 0, in any state including mid-trap; Reset has priority over every request.

Structure
REQ-036 State encoding, tt constants (0x02, 0x03, 0x05, 0x06, 0x10) and the NWINDOWS default SHALL reside in the shared processor package.
REQ-037 The modular CWP increment/decrement SHALL be one sub-module, cwp_wrap_unit, instantiated twice.

Verification
REQ-038 CWP = 0, WIM = 0x8000_0000, Save_Req -> overflow trap: TRAP_SAVE New_CWP = 31, New_ET = 0, New_S = 1, then Trap_Taken with Trap_Type = 0x05.
REQ-039 CWP = 31, WIM = 0, Restore_Req -> PSR_Fld_Ld next cycle with New_CWP = 0 and Busy = 0.
REQ-040 ET = 1, PIL = 4, Interrupt_Level = 4 -> no trap; Interrupt_Level = 5 -> Trap_Type = 0x15; Interrupt_Level = 15 with PIL = 15 -> Trap_Type = 0x1F.
REQ-041 S = 0, Priv_Op = 1 together with Save_Req into an invalid window -> Trap_Type = 0x03, and no overflow trap is raised.
REQ-042 ET = 0, Restore_Req into an invalid window -> Error_Mode = 1 and Busy held high; Reset -> all outputs return to 0.
REQ-043 Reset asserted during TRAP_SAVE -> IDLE next cycle and Trap_Taken is never asserted.

Source files
------------

// File: rtl/window_trap_controller_pkg.sv
// Shared definitions for the register-window trap controller: FSM states,
// trap type codes and the default window count.
package window_trap_controller_pkg;

  localparam int NWINDOWS_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_TRAP_SAVE   = 2'd1,
    ST_TRAP_VECTOR = 2'd2,
    ST_ERROR       = 2'd3
  } ctrl_state_t;

  localparam logic [7:0] TT_ILLEGAL          = 8'h02;
  localparam logic [7:0] TT_PRIVILEGED       = 8'h03;
  localparam logic [7:0] TT_WINDOW_OVERFLOW  = 8'h05;
  localparam logic [7:0] TT_WINDOW_UNDERFLOW = 8'h06;
  localparam logic [7:0] TT_INTERRUPT_BASE   = 8'h10;

  function automatic logic [7:0] interrupt_tt(input logic [3:0] level);
    return TT_INTERRUPT_BASE | {4'h0, level};
  endfunction

endpackage

// File: rtl/window_trap_controller_cwp_wrap_unit.sv
// Modular window-pointer step: one position up or down, wrapping within
// 0..NWINDOWS-1.
module cwp_wrap_unit
  import window_trap_controller_pkg::*;
#(
  parameter int NWINDOWS = NWINDOWS_DEFAULT
) (
  input  logic [4:0] cwp,
  input  logic       increment,
  output logic [4:0] result
);

  localparam logic [4:0] LAST = 5'(NWINDOWS - 1);

  always_comb begin
    if (increment) begin
      result = (cwp == LAST) ? 5'd0 : cwp + 5'd1;
    end else begin
      result = (cwp == 5'd0) ? LAST : cwp - 5'd1;
    end
  end

endmodule

// File: rtl/window_trap_controller.sv
// Window trap controller: checks SAVE/RESTORE/RETT and interrupts in IDLE,
// issues PSR field updates and sequences traps through save and vector steps.
//   state          | meaning
//   ST_IDLE        | accepting requests; legal window ops update PSR next cycle
//   ST_TRAP_SAVE   | PSR loads S=1, ET=0, PS=S, CWP=down
//   ST_TRAP_VECTOR | Trap_Taken pulse with latched Trap_Type
//   ST_ERROR       | trap with ET=0; held until Reset
module window_trap_controller
  import window_trap_controller_pkg::*;
#(
  parameter int NWINDOWS = NWINDOWS_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PSR_S,
  input  logic        PSR_PS,
  input  logic        PSR_ET,
  input  logic [4:0]  PSR_CWP,
  input  logic [3:0]  PSR_PIL,
  input  logic [31:0] WIM,
  input  logic        Save_Req,
  input  logic        Restore_Req,
  input  logic        Rett_Req,
  input  logic        Priv_Op,
  input  logic [3:0]  Interrupt_Level,
  output logic        Busy,
  output logic        Trap_Taken,
  output logic [7:0]  Trap_Type,
  output logic        PSR_Fld_Ld,
  output logic        New_S,
  output logic        New_PS,
  output logic        New_ET,
  output logic [4:0]  New_CWP,
  output logic        Error_Mode
);

  ctrl_state_t state_q, state_d;
  logic       trap_taken_q, trap_taken_d;
  logic [7:0] tt_q, tt_d;
  logic       fld_ld_q, fld_ld_d;
  logic       new_s_q, new_s_d, new_ps_q, new_ps_d, new_et_q, new_et_d;
  logic [4:0] new_cwp_q, new_cwp_d;
  logic       error_q, error_d;

  logic [4:0] cwp_down, cwp_up;

  cwp_wrap_unit #(.NWINDOWS(NWINDOWS)) u_cwp_down (
    .cwp(PSR_CWP), .increment(1'b0), .result(cwp_down)
  );

  cwp_wrap_unit #(.NWINDOWS(NWINDOWS)) u_cwp_up (
    .cwp(PSR_CWP), .increment(1'b1), .result(cwp_up)
  );

  logic rett_illegal, privileged, rett_legal, overflow, underflow, interrupt;

  assign rett_illegal = Rett_Req & PSR_ET;
  assign privileged   = (Priv_Op & ~PSR_S) | (Rett_Req & ~PSR_S & ~PSR_ET);
  assign rett_legal   = Rett_Req & ~PSR_ET & PSR_S;
  assign overflow     = Save_Req & WIM[cwp_down];
  // A simultaneous RESTORE is subsumed by SAVE, so it must not underflow.
  assign underflow    = ((Restore_Req & ~Save_Req) | rett_legal) & WIM[cwp_up];
  assign interrupt    = PSR_ET & (Interrupt_Level != 4'd0) &
                        ((Interrupt_Level == 4'hF) | (Interrupt_Level > PSR_PIL));

  logic       trap_hit;
  logic [7:0] tt_sel;

  always_comb begin
    trap_hit = 1'b1;
    tt_sel   = 8'h00;
    if (rett_illegal)    tt_sel = TT_ILLEGAL;
    else if (privileged) tt_sel = TT_PRIVILEGED;
    else if (overflow)   tt_sel = TT_WINDOW_OVERFLOW;
    else if (underflow)  tt_sel = TT_WINDOW_UNDERFLOW;
    else if (interrupt)  tt_sel = interrupt_tt(Interrupt_Level);
    else                 trap_hit = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    trap_taken_d = 1'b0;
    fld_ld_d     = 1'b0;
    tt_d         = tt_q;
    new_s_d      = new_s_q;
    new_ps_d     = new_ps_q;
    new_et_d     = new_et_q;
    new_cwp_d    = new_cwp_q;
    error_d      = error_q;
    case (state_q)
      ST_IDLE: begin
        if (trap_hit) begin
          tt_d = tt_sel;
          if (!PSR_ET) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            // Trap entry decrements CWP without consulting WIM.
            state_d   = ST_TRAP_SAVE;
            fld_ld_d  = 1'b1;
            new_s_d   = 1'b1;
            new_ps_d  = PSR_S;
            new_et_d  = 1'b0;
            new_cwp_d = cwp_down;
          end
        end else if (Save_Req) begin
          fld_ld_d  = 1'b1;
          new_s_d   = PSR_S;
          new_ps_d  = PSR_PS;
          new_et_d  = PSR_ET;
          new_cwp_d = cwp_down;
        end else if (Restore_Req) begin
          fld_ld_d  = 1'b1;
          new_s_d   = PSR_S;
          new_ps_d  = PSR_PS;
          new_et_d  = PSR_ET;
          new_cwp_d = cwp_up;
        end else if (rett_legal) begin
          fld_ld_d  = 1'b1;
          new_s_d   = PSR_PS;
          new_ps_d  = PSR_PS;
          new_et_d  = 1'b1;
          new_cwp_d = cwp_up;
        end
      end
      ST_TRAP_SAVE: begin
        state_d      = ST_TRAP_VECTOR;
        trap_taken_d = 1'b1;
      end
      ST_TRAP_VECTOR: state_d = ST_IDLE;
      ST_ERROR:       state_d = ST_ERROR;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      trap_taken_q <= 1'b0;
      tt_q         <= 8'h00;
      fld_ld_q     <= 1'b0;
      new_s_q      <= 1'b0;
      new_ps_q     <= 1'b0;
      new_et_q     <= 1'b0;
      new_cwp_q    <= 5'd0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      trap_taken_q <= trap_taken_d;
      tt_q         <= tt_d;
      fld_ld_q     <= fld_ld_d;
      new_s_q      <= new_s_d;
      new_ps_q     <= new_ps_d;
      new_et_q     <= new_et_d;
      new_cwp_q    <= new_cwp_d;
      error_q      <= error_d;
    end
  end

  assign Busy       = (state_q != ST_IDLE);
  assign Trap_Taken = trap_taken_q;
  assign Trap_Type  = tt_q;
  assign PSR_Fld_Ld = fld_ld_q;
  assign New_S      = new_s_q;
  assign New_PS     = new_ps_q;
  assign New_ET     = new_et_q;
  assign New_CWP    = new_cwp_q;
  assign Error_Mode = error_q;

endmodule

// File: tb/tb_window_trap_controller.sv
// Self-checking bench for window_trap_controller: directed corner cases then
// randomized requests against a rule-level reference model.
module tb_window_trap_controller;

  localparam int NW = 32;

  logic        Clock;
  logic        Reset;
  logic        PSR_S, PSR_PS, PSR_ET;
  logic [4:0]  PSR_CWP;
  logic [3:0]  PSR_PIL;
  logic [31:0] WIM;
  logic        Save_Req, Restore_Req, Rett_Req, Priv_Op;
  logic [3:0]  Interrupt_Level;
  logic        Busy, Trap_Taken, PSR_Fld_Ld, New_S, New_PS, New_ET, Error_Mode;
  logic [7:0]  Trap_Type;
  logic [4:0]  New_CWP;

  int tests = 0;
  int failed = 0;

  window_trap_controller #(.NWINDOWS(NW)) dut (
    .Clock(Clock), .Reset(Reset),
    .PSR_S(PSR_S), .PSR_PS(PSR_PS), .PSR_ET(PSR_ET),
    .PSR_CWP(PSR_CWP), .PSR_PIL(PSR_PIL), .WIM(WIM),
    .Save_Req(Save_Req), .Restore_Req(Restore_Req), .Rett_Req(Rett_Req),
    .Priv_Op(Priv_Op), .Interrupt_Level(Interrupt_Level),
    .Busy(Busy), .Trap_Taken(Trap_Taken), .Trap_Type(Trap_Type),
    .PSR_Fld_Ld(PSR_Fld_Ld), .New_S(New_S), .New_PS(New_PS), .New_ET(New_ET),
    .New_CWP(New_CWP), .Error_Mode(Error_Mode)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    Save_Req = 0; Restore_Req = 0; Rett_Req = 0; Priv_Op = 0; Interrupt_Level = 4'd0;
  endtask

  function automatic logic [31:0] all_outputs();
    return {14'd0, Busy, Trap_Taken, Trap_Type, PSR_Fld_Ld, New_S, New_PS, New_ET, New_CWP, Error_Mode};
  endfunction

  task automatic do_reset(input string tag);
    clear_reqs();
    Reset = 1;
    tick();
    check({tag, "_reset_outputs"}, all_outputs(), 32'd0);
    Reset = 0;
  endtask

  // op: 0 none, 1 save, 2 restore, 3 rett, 4 save+restore
  task automatic run_case(input string tag, input int cwp, input logic [31:0] wim,
                          input bit s, input bit ps, input bit et, input int pil,
                          input int lvl, input int op, input bit priv);
    int down, up, tt;
    bit save, restore, rett;
    logic [7:0] exp_new;
    down = (cwp + NW - 1) % NW;
    up   = (cwp + 1) % NW;
    save    = (op == 1) || (op == 4);
    restore = (op == 2);
    rett    = (op == 3);

    tt = -1;
    if (rett && et)                                 tt = 2;
    else if ((priv && !s) || (rett && !s && !et))   tt = 3;
    else if (save && wim[down])                     tt = 5;
    else if ((restore || rett) && wim[up])          tt = 6;
    else if (et && lvl != 0 && (lvl == 15 || lvl > pil)) tt = 16 + lvl;

    PSR_S = s; PSR_PS = ps; PSR_ET = et; PSR_CWP = 5'(cwp); PSR_PIL = 4'(pil);
    WIM = wim;
    Save_Req = (op == 1) || (op == 4);
    Restore_Req = (op == 2) || (op == 4);
    Rett_Req = rett; Priv_Op = priv; Interrupt_Level = 4'(lvl);
    tick();
    clear_reqs();

    if (tt >= 0 && !et) begin
      check({tag, "_err_mode"}, {31'd0, Error_Mode}, 32'd1);
      check({tag, "_err_busy"}, {31'd0, Busy}, 32'd1);
      check({tag, "_err_noload"}, {30'd0, PSR_Fld_Ld, Trap_Taken}, 32'd0);
      WIM = 32'd0; Save_Req = 1;
      tick(); tick();
      check({tag, "_err_held"}, {29'd0, Busy, Error_Mode, PSR_Fld_Ld}, 32'd6);
      do_reset(tag);
    end else if (tt >= 0) begin
      exp_new = {1'b1, s, 1'b0, 5'(down)};
      check({tag, "_save_step"}, {29'd0, Busy, PSR_Fld_Ld, Trap_Taken}, 32'd6);
      check({tag, "_save_fields"}, {24'd0, New_S, New_PS, New_ET, New_CWP}, {24'd0, exp_new});
      // a legal SAVE while busy must be ignored
      WIM = 32'd0; Save_Req = 1;
      tick();
      check({tag, "_vector_step"}, {29'd0, Busy, PSR_Fld_Ld, Trap_Taken}, 32'd5);
      check({tag, "_trap_type"}, {24'd0, Trap_Type}, 32'(tt));
      tick();
      check({tag, "_back_idle"}, {29'd0, Busy, PSR_Fld_Ld, Trap_Taken}, 32'd0);
      Save_Req = 0;
      tick();
    end else if (save || restore || rett) begin
      if (rett)      exp_new = {ps, ps, 1'b1, 5'(up)};
      else if (save) exp_new = {s, ps, et, 5'(down)};
      else           exp_new = {s, ps, et, 5'(up)};
      check({tag, "_legal_step"}, {29'd0, Busy, PSR_Fld_Ld, Trap_Taken}, 32'd2);
      check({tag, "_legal_fields"}, {24'd0, New_S, New_PS, New_ET, New_CWP}, {24'd0, exp_new});
      tick();
      check({tag, "_legal_pulse"}, {31'd0, PSR_Fld_Ld}, 32'd0);
    end else begin
      check({tag, "_no_action"}, {29'd0, Busy, PSR_Fld_Ld, Trap_Taken}, 32'd0);
      tick();
      check({tag, "_no_action2"}, {29'd0, Busy, PSR_Fld_Ld, Trap_Taken}, 32'd0);
    end
  endtask

  initial begin
    clear_reqs();
    PSR_S = 0; PSR_PS = 0; PSR_ET = 0; PSR_CWP = 0; PSR_PIL = 0; WIM = 0;
    Reset = 1;
    tick(); tick();
    check("initial_reset", all_outputs(), 32'd0);
    Reset = 0;
    tick();

    //        tag          cwp wim           s  ps et pil lvl op priv
    run_case("ovf_wrap",    0, 32'h8000_0000, 1, 0, 1, 0,  0,  1, 0);
    run_case("rst_wrap",   31, 32'h0,         1, 1, 1, 0,  0,  2, 0);
    run_case("save_wrap",   0, 32'h0,         0, 1, 1, 0,  0,  1, 0);
    run_case("irq_eq",      3, 32'h0,         1, 0, 1, 4,  4,  0, 0);
    run_case("irq_gt",      3, 32'h0,         1, 0, 1, 4,  5,  0, 0);
    run_case("irq_15",      3, 32'h0,         1, 0, 1, 15, 15, 0, 0);
    run_case("irq_zero",    3, 32'h0,         1, 0, 1, 0,  0,  0, 0);
    run_case("priv_ovf",    7, 32'h0000_0040, 0, 0, 1, 0,  0,  1, 1);
    run_case("err_unf",     5, 32'h0000_0040, 1, 0, 0, 0,  0,  2, 0);
    run_case("rett_ill",    9, 32'h0,         1, 0, 1, 0,  0,  3, 0);
    run_case("rett_ok",    31, 32'h0,         1, 0, 0, 0,  0,  3, 0);
    run_case("rett_unf",   10, 32'h0000_0800, 1, 1, 0, 0,  0,  3, 0);
    run_case("save_rest",   4, 32'h0000_0020, 1, 0, 1, 0,  0,  4, 0);

    // reset while in TRAP_SAVE: the vector step must never occur
    PSR_S = 1; PSR_ET = 1; PSR_CWP = 0; WIM = 32'h8000_0000; Save_Req = 1;
    tick();
    clear_reqs();
    check("midtrap_busy", {31'd0, Busy}, 32'd1);
    Reset = 1;
    tick();
    check("midtrap_reset", all_outputs(), 32'd0);
    Reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midtrap_no_vector", {30'd0, Trap_Taken, Busy}, 32'd0);
    end

    for (int n = 0; n < 250; n++) begin
      int op, lvl;
      op  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
      lvl = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 15);
      run_case("rand", $urandom_range(0, NW - 1), $urandom() & $urandom() & $urandom(),
               1'($urandom()), 1'($urandom()), 1'($urandom()), $urandom_range(0, 15),
               lvl, op, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
